// File: rtl/fighter_pixel_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : fighter_pixel_renderer_if
// Description : Pixel-stream and game-state bundle between the VGA timing /
//               game logic side (master) and the fighter pixel renderer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fighter_pixel_renderer_if;
    logic        p_tick;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hsync_in;
    logic        vsync_in;

    logic [9:0]  p1_x;
    logic [9:0]  p2_x;
    logic [8:0]  p1_y;
    logic [8:0]  p2_y;
    logic        p1_face;
    logic        p2_face;
    logic        p1_atk;
    logic        p2_atk;
    logic        p1_hit;
    logic        p2_hit;
    logic [6:0]  p1_hp;
    logic [6:0]  p2_hp;

    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;

    modport master (
        output p_tick, video_on, x, y, hsync_in, vsync_in,
        output p1_x, p2_x, p1_y, p2_y, p1_face, p2_face,
        output p1_atk, p2_atk, p1_hit, p2_hit, p1_hp, p2_hp,
        input  rgb, hsync, vsync
    );

    modport slave (
        input  p_tick, video_on, x, y, hsync_in, vsync_in,
        input  p1_x, p2_x, p1_y, p2_y, p1_face, p2_face,
        input  p1_atk, p2_atk, p1_hit, p2_hit, p1_hp, p2_hp,
        output rgb, hsync, vsync
    );
endinterface
`default_nettype wire

// File: rtl/fighter_pixel_renderer.sv
`default_nettype none
// ============================================================================
// Module      : fighter_pixel_renderer
// Description : Two-stage pixel colour pipeline for a two-player fighting game
//               (sky, ground, fighters with arms, health bars). Optional
//               HITBOX_OVERLAY_EN macro adds a magenta outline on active arms.
// Revision    : 1.0 - initial release
// ============================================================================
module fighter_pixel_renderer #(
    parameter int FW       = 32,
    parameter int FH       = 64,
    parameter int ATK_W    = 24,
    parameter int ATK_H    = 8,
    parameter int GROUND_Y = 400,
    parameter int BAR_Y    = 16,
    parameter int BAR_H    = 8,
    parameter int HP_MAX   = 100
) (
    input  logic                    clk_50MHz,
    input  logic                    reset_n,
    fighter_pixel_renderer_if.slave pix
);

    localparam logic [10:0] c_fw        = 11'(FW);
    localparam logic [10:0] c_fh        = 11'(FH);
    localparam logic [10:0] c_atk_w     = 11'(ATK_W);
    localparam logic [10:0] c_atk_h     = 11'(ATK_H);
    localparam logic [10:0] c_atk_off   = 11'd24;
    localparam logic [10:0] c_ground_y  = 11'(GROUND_Y);
    localparam logic [10:0] c_bar_y     = 11'(BAR_Y);
    localparam logic [10:0] c_bar_h     = 11'(BAR_H);
    localparam logic [10:0] c_bar_len   = 11'(2 * HP_MAX);
    localparam logic [10:0] c_bar_p1_x0 = 11'd16;
    localparam logic [10:0] c_bar_p2_x1 = 11'd623;
    localparam logic [6:0]  c_hp_max    = 7'(HP_MAX);

    typedef struct packed {
        logic [9:0] px;
        logic [8:0] py;
        logic       face;
        logic       atk;
        logic       hit;
        logic [6:0] hp;
    } fighter_t;

    typedef struct packed {
        logic vid;
        logic hs;
        logic vs;
        logic bar_on;
        logic bar_fill;
        logic p1_body;
        logic p1_arm;
        logic p1_blink;
        logic p2_body;
        logic p2_arm;
        logic p2_blink;
        logic ground;
`ifdef HITBOX_OVERLAY_EN
        logic ovl;
`endif
    } stage1_t;

    fighter_t    p1_q, p1_d, p2_q, p2_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    stage1_t     s1_q, s1_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;

    logic [10:0] w_xe, w_ye;
    logic        w_frame_start;
    logic        w_bar_rows, w_p1_bar, w_p2_bar, w_p1_fill, w_p2_fill;

    // All geometry is compared in 11 bits so box edges near x=1023 never wrap.
    function automatic logic body_hit(input fighter_t f, input logic [10:0] xe,
                                      input logic [10:0] ye);
        logic [10:0] px, py;
        px = {1'b0, f.px};
        py = {2'b0, f.py};
        return (xe >= px) && (xe < px + c_fw) && (ye >= py) && (ye < py + c_fh);
    endfunction

    // A left-facing arm spans [px-ATK_W, px-1]; written as an addition on x so
    // the left edge clips at column 0 without a signed compare.
    function automatic logic arm_hit(input fighter_t f, input logic [10:0] xe,
                                     input logic [10:0] ye);
        logic [10:0] px, py;
        logic        cols, rows;
        px   = {1'b0, f.px};
        py   = {2'b0, f.py};
        cols = f.face ? ((xe < px) && (xe + c_atk_w >= px))
                      : ((xe >= px + c_fw) && (xe < px + c_fw + c_atk_w));
        rows = (ye >= py + c_atk_off) && (ye < py + c_atk_off + c_atk_h);
        return f.atk && cols && rows;
    endfunction

`ifdef HITBOX_OVERLAY_EN
    function automatic logic arm_edge(input fighter_t f, input logic [10:0] xe,
                                      input logic [10:0] ye);
        logic [10:0] px, py, lo, hi, top, bot;
        px  = {1'b0, f.px};
        py  = {2'b0, f.py};
        lo  = f.face ? ((px >= c_atk_w) ? px - c_atk_w : 11'd0) : px + c_fw;
        hi  = f.face ? px - 11'd1 : px + c_fw + c_atk_w - 11'd1;
        top = py + c_atk_off;
        bot = top + c_atk_h - 11'd1;
        return arm_hit(f, xe, ye) && ((xe == lo) || (xe == hi) || (ye == top) || (ye == bot));
    endfunction
`endif

    function automatic logic [6:0] sat_hp(input logic [6:0] hp);
        return (hp > c_hp_max) ? c_hp_max : hp;
    endfunction

    assign w_xe          = {1'b0, pix.x};
    assign w_ye          = {1'b0, pix.y};
    assign w_frame_start = pix.p_tick && (pix.x == 10'd0) && (pix.y == 10'd480);

    assign w_bar_rows = (w_ye >= c_bar_y) && (w_ye < c_bar_y + c_bar_h);
    assign w_p1_bar   = (w_xe >= c_bar_p1_x0) && (w_xe < c_bar_p1_x0 + c_bar_len);
    assign w_p2_bar   = (w_xe + c_bar_len > c_bar_p2_x1) && (w_xe <= c_bar_p2_x1);
    assign w_p1_fill  = w_xe < c_bar_p1_x0 + {3'b0, p1_q.hp, 1'b0};
    assign w_p2_fill  = w_xe + {3'b0, p2_q.hp, 1'b0} > c_bar_p2_x1;

    // Game state is captured once per frame during vertical blanking.
    always_comb begin
        p1_d        = p1_q;
        p2_d        = p2_q;
        frame_cnt_d = frame_cnt_q;
        if (w_frame_start) begin
            p1_d.px     = pix.p1_x;
            p1_d.py     = pix.p1_y;
            p1_d.face   = pix.p1_face;
            p1_d.atk    = pix.p1_atk;
            p1_d.hit    = pix.p1_hit;
            p1_d.hp     = sat_hp(pix.p1_hp);
            p2_d.px     = pix.p2_x;
            p2_d.py     = pix.p2_y;
            p2_d.face   = pix.p2_face;
            p2_d.atk    = pix.p2_atk;
            p2_d.hit    = pix.p2_hit;
            p2_d.hp     = sat_hp(pix.p2_hp);
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_comb begin
        s1_d = s1_q;
        if (pix.p_tick) begin
            s1_d.vid      = pix.video_on;
            s1_d.hs       = pix.hsync_in;
            s1_d.vs       = pix.vsync_in;
            s1_d.bar_on   = w_bar_rows && (w_p1_bar || w_p2_bar);
            s1_d.bar_fill = w_bar_rows && ((w_p1_bar && w_p1_fill) || (w_p2_bar && w_p2_fill));
            s1_d.p1_body  = body_hit(p1_q, w_xe, w_ye);
            s1_d.p1_arm   = arm_hit(p1_q, w_xe, w_ye);
            s1_d.p1_blink = p1_q.hit && frame_cnt_q[3];
            s1_d.p2_body  = body_hit(p2_q, w_xe, w_ye);
            s1_d.p2_arm   = arm_hit(p2_q, w_xe, w_ye);
            s1_d.p2_blink = p2_q.hit && frame_cnt_q[3];
            s1_d.ground   = w_ye >= c_ground_y;
`ifdef HITBOX_OVERLAY_EN
            s1_d.ovl      = arm_edge(p1_q, w_xe, w_ye) || arm_edge(p2_q, w_xe, w_ye);
`endif
        end
    end

    always_comb begin
        rgb_d   = rgb_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (pix.p_tick) begin
            hsync_d = s1_q.hs;
            vsync_d = s1_q.vs;
            if (!s1_q.vid)
                rgb_d = 12'h000;
`ifdef HITBOX_OVERLAY_EN
            else if (s1_q.ovl)
                rgb_d = 12'hF0F;
`endif
            else if (s1_q.bar_on)
                rgb_d = s1_q.bar_fill ? 12'h0F0 : 12'h400;
            else if (s1_q.p1_body)
                rgb_d = s1_q.p1_blink ? 12'hFFF : 12'h00F;
            else if (s1_q.p1_arm)
                rgb_d = s1_q.p1_blink ? 12'hFFF : 12'h008;
            else if (s1_q.p2_body)
                rgb_d = s1_q.p2_blink ? 12'hFFF : 12'hF00;
            else if (s1_q.p2_arm)
                rgb_d = s1_q.p2_blink ? 12'hFFF : 12'h800;
            else if (s1_q.ground)
                rgb_d = 12'h640;
            else
                rgb_d = 12'h6AF;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            p1_q        <= '0;
            p2_q        <= '0;
            frame_cnt_q <= '0;
            s1_q        <= '0;
            rgb_q       <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            frame_cnt_q <= frame_cnt_d;
            s1_q        <= s1_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign pix.rgb   = rgb_q;
    assign pix.hsync = hsync_q;
    assign pix.vsync = vsync_q;

endmodule
`default_nettype wire
